axis_align: RTL and testbench

//  AXI4-Stream byte re-packer for one stream. Input packets may start mid-word (first-beat tkeep MSB-contiguous).
//  It repacks every packet so all output beats are full (tkeep all ones), except the last beat, which is LSB-contiguous.

---
 rtl/axis_align_pkg.sv | 26 ++
 rtl/axis_align_shift.sv | 24 ++
 rtl/axis_align.sv | 139 +++++++++++++
 tb/tb_axis_align.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/axis_align_pkg.sv
// axis_align_pkg: shared byte-lane helpers for the AXI4-Stream re-packer
package axis_align_pkg;
  localparam int BYTE_W = 8;
  localparam int MAX_KW = 64;

  function automatic logic [7:0] popcount_keep(input logic [MAX_KW-1:0] k);
    logic [7:0] c;
    c = '0;
    for (int i = 0; i < MAX_KW; i++) c += {7'd0, k[i]};
    return c;
  endfunction

  function automatic logic [7:0] tz_keep(input logic [MAX_KW-1:0] k);
    logic [7:0] t;
    t = '0;
    for (int i = MAX_KW - 1; i >= 0; i--) if (k[i]) t = 8'(i);
    return t;
  endfunction

  function automatic logic [MAX_KW-1:0] keep_lsb_mask(input logic [7:0] n);
    logic [MAX_KW-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_KW; i++) m[i] = 8'(i) < n;
    return m;
  endfunction
endpackage

// File: rtl/axis_align_shift.sv
// axis_align_shift: merges residual bytes with the valid bytes of a new beat into one 2*KW-byte word
module axis_align_shift
  import axis_align_pkg::*;
#(
  parameter int KW = 8,
  parameter int CW = 4
) (
  input  logic [KW*BYTE_W-1:0]   data_i,
  input  logic [KW-1:0]          keep_i,
  input  logic [CW-1:0]          lo_i,
  input  logic [KW*BYTE_W-1:0]   res_i,
  input  logic [CW-1:0]          r_i,
  output logic [2*KW*BYTE_W-1:0] merged_o
);
  logic [KW*BYTE_W-1:0] kd;
  logic [KW*BYTE_W-1:0] aligned;

  for (genvar i = 0; i < KW; i++) begin : g_kd
    assign kd[i*BYTE_W +: BYTE_W] = {BYTE_W{keep_i[i]}};
  end

  assign aligned  = (data_i & kd) >> {lo_i, 3'b000};
  assign merged_o = ({{KW*BYTE_W{1'b0}}, aligned} << {r_i, 3'b000}) | {{KW*BYTE_W{1'b0}}, res_i};
endmodule

// File: rtl/axis_align.sv
// axis_align: AXI4-Stream byte re-packer producing full beats; AXIS_ALIGN_SVA_EN compiles in protocol assertions
module axis_align
  import axis_align_pkg::*;
#(
  parameter  int AXIS_DW = 64,
  localparam int AXIS_KW = ((AXIS_DW-1)>>3)+1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               s_axis_tvalid,
  output logic               s_axis_tready,
  input  logic [AXIS_DW-1:0] s_axis_tdata,
  input  logic [AXIS_KW-1:0] s_axis_tkeep,
  input  logic               s_axis_tlast,
  output logic               m_axis_tvalid,
  input  logic               m_axis_tready,
  output logic [AXIS_DW-1:0] m_axis_tdata,
  output logic [AXIS_KW-1:0] m_axis_tkeep,
  output logic               m_axis_tlast
);
  localparam int CW = $clog2(AXIS_KW) + 1;

  logic [CW-1:0] n, lo, total, rem, r_q, r_d;
  logic [AXIS_DW-1:0] res_q, res_d, m_data_q, m_data_d;
  logic [AXIS_KW-1:0] m_keep_q, m_keep_d;
  logic m_valid_q, m_valid_d, m_last_q, m_last_d, flush_q, flush_d;
  logic [2*AXIS_DW-1:0] merged;
  logic acc, free;

  assign n             = CW'(popcount_keep(MAX_KW'(s_axis_tkeep)));
  assign lo            = CW'(tz_keep(MAX_KW'(s_axis_tkeep)));
  assign total         = r_q + n;
  assign rem           = total - CW'(AXIS_KW);
  assign free          = !m_valid_q | m_axis_tready;
  assign s_axis_tready = rst & !flush_q & free;
  assign acc           = s_axis_tvalid & s_axis_tready;

  assign m_axis_tvalid = m_valid_q;
  assign m_axis_tdata  = m_data_q;
  assign m_axis_tkeep  = m_keep_q;
  assign m_axis_tlast  = m_last_q;

  axis_align_shift #(.KW(AXIS_KW), .CW(CW)) u_shift (
    .data_i   (s_axis_tdata),
    .keep_i   (s_axis_tkeep),
    .lo_i     (lo),
    .res_i    (res_q),
    .r_i      (r_q),
    .merged_o (merged)
  );

  // Next state: residual flush has priority, otherwise pack the accepted beat behind the residual
  always_comb begin
    m_valid_d = m_valid_q & !m_axis_tready;
    m_data_d  = m_data_q;
    m_keep_d  = m_keep_q;
    m_last_d  = m_last_q;
    r_d       = r_q;
    res_d     = res_q;
    flush_d   = flush_q;
    if (flush_q & free) begin
      m_valid_d = 1'b1;
      m_data_d  = res_q;
      m_keep_d  = AXIS_KW'(keep_lsb_mask(8'(r_q)));
      m_last_d  = 1'b1;
      r_d       = '0;
      res_d     = '0;
      flush_d   = 1'b0;
    end else if (acc) begin
      if (total >= CW'(AXIS_KW)) begin
        m_valid_d = 1'b1;
        m_data_d  = merged[AXIS_DW-1:0];
        m_keep_d  = '1;
        m_last_d  = s_axis_tlast & (rem == '0);
        flush_d   = s_axis_tlast & (rem != '0);
        r_d       = rem;
        res_d     = merged[2*AXIS_DW-1:AXIS_DW];
      end else if (s_axis_tlast) begin
        m_valid_d = 1'b1;
        m_data_d  = merged[AXIS_DW-1:0];
        m_keep_d  = AXIS_KW'(keep_lsb_mask(8'(total)));
        m_last_d  = 1'b1;
        r_d       = '0;
        res_d     = '0;
      end else begin
        r_d   = total;
        res_d = merged[AXIS_DW-1:0];
      end
    end
  end

  // State and output registers, all cleared while rst is low
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_keep_q  <= '0;
      m_last_q  <= 1'b0;
      r_q       <= '0;
      res_q     <= '0;
      flush_q   <= 1'b0;
    end else begin
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_keep_q  <= m_keep_d;
      m_last_q  <= m_last_d;
      r_q       <= r_d;
      res_q     <= res_d;
      flush_q   <= flush_d;
    end
  end

`ifdef AXIS_ALIGN_SVA_EN
  logic first_q;
  logic [AXIS_KW-1:0] kn;

  assign kn = s_axis_tkeep >> lo;

  // Tracks whether the next accepted input beat opens a packet
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) first_q <= 1'b1;
    else if (acc) first_q <= s_axis_tlast;
  end

  a_keep_legal: assert property (@(posedge clk) disable iff (!rst)
    s_axis_tvalid |-> (s_axis_tkeep != '0) && ((kn & (kn + AXIS_KW'(1))) == '0) &&
      (s_axis_tlast ? s_axis_tkeep[0] : (first_q ? s_axis_tkeep[AXIS_KW-1] : &s_axis_tkeep)));

  a_s_stable: assert property (@(posedge clk) disable iff (!rst)
    s_axis_tvalid && !s_axis_tready |=> s_axis_tvalid && $stable({s_axis_tdata, s_axis_tkeep, s_axis_tlast}));

  a_m_stable: assert property (@(posedge clk) disable iff (!rst)
    m_valid_q && !m_axis_tready |=> m_valid_q && $stable({m_data_q, m_keep_q, m_last_q}));

  a_m_full: assert property (@(posedge clk) disable iff (!rst)
    m_valid_q && !m_last_q |-> &m_keep_q);
`else
`endif
endmodule

// File: tb/tb_axis_align.sv
// tb_axis_align: randomized scoreboard bench for axis_align with a byte-stream reference model
module tb_axis_align;
  localparam int DW = 64;
  localparam int KW = 8;

  logic clk = 1'b0;
  logic rst;
  logic s_valid, s_ready, s_last, m_valid, m_ready, m_last;
  logic [DW-1:0] s_data, m_data;
  logic [KW-1:0] s_keep, m_keep;

  typedef struct packed {
    logic          l;
    logic [KW-1:0] k;
    logic [DW-1:0] d;
  } beat_t;

  beat_t exp_q[$];
  beat_t pkt_q[$];
  int n_chk = 0;
  int n_pass = 0;
  bit gaps = 1'b0;
  bit rnd_ready = 1'b0;

  axis_align #(.AXIS_DW(DW)) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tvalid (s_valid),
    .s_axis_tready (s_ready),
    .s_axis_tdata  (s_data),
    .s_axis_tkeep  (s_keep),
    .s_axis_tlast  (s_last),
    .m_axis_tvalid (m_valid),
    .m_axis_tready (m_ready),
    .m_axis_tdata  (m_data),
    .m_axis_tkeep  (m_keep),
    .m_axis_tlast  (m_last)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic add(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l);
    beat_t b;
    b.d = d;
    b.k = k;
    b.l = l;
    pkt_q.push_back(b);
  endtask

  task automatic model_pkt();
    logic [7:0] bq[$];
    foreach (pkt_q[b])
      for (int i = 0; i < KW; i++)
        if (pkt_q[b].k[i]) bq.push_back(pkt_q[b].d[8*i +: 8]);
    while (bq.size() > 0) begin
      beat_t e;
      int cnt;
      e = '0;
      cnt = bq.size() < KW ? bq.size() : KW;
      for (int j = 0; j < cnt; j++) e.d[8*j +: 8] = bq.pop_front();
      e.k = KW'((1 << cnt) - 1);
      e.l = bq.size() == 0;
      exp_q.push_back(e);
    end
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l);
    bit ok;
    ok = 1'b0;
    s_valid = 1'b1;
    s_data  = d;
    s_keep  = k;
    s_last  = l;
    for (int t = 0; t < 1000 && !ok; t++) begin
      @(negedge clk);
      ok = s_ready;
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      $display("FAIL send_timeout: s_axis_tready never rose, required 1");
      $fatal(1);
    end
    s_valid = 1'b0;
  endtask

  task automatic send_pkt();
    model_pkt();
    foreach (pkt_q[b]) begin
      if (gaps && ($urandom % 2 == 1)) begin
        @(posedge clk);
        #1;
      end
      send_beat(pkt_q[b].d, pkt_q[b].k, pkt_q[b].l);
    end
    pkt_q.delete();
  endtask

  task automatic drain();
    for (int t = 0; t < 2000 && exp_q.size() > 0; t++) @(posedge clk);
    #1;
    chk("drain_remaining", exp_q.size(), 0);
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    if (rnd_ready) m_ready = $urandom % 2;
  end

  initial forever begin
    @(negedge clk);
    if (rst && m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_beat: got %h expected none", {m_last, m_keep, m_data});
      end else begin
        beat_t e;
        e = exp_q.pop_front();
        chk("out_beat", 128'({m_last, m_keep, m_data}), 128'(e));
      end
    end
  end

  initial begin
    rst = 1'b0;
    s_valid = 1'b0;
    s_data = '0;
    s_keep = '0;
    s_last = 1'b0;
    m_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {m_valid, m_last, m_keep, m_data}, 0);
    chk("reset_tready", s_ready, 0);
    rst = 1'b1;
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("tready_after_reset", s_ready, 1);

    add(64'h1122334455CCBBAA, 8'h07, 1'b1);
    send_pkt();
    chk("single_latency", m_valid, 1);

    add(64'hA1A0123456789ABC, 8'hC0, 1'b0);
    add(64'hEEB5B4B3B2B1B0, 8'h3F, 1'b1);
    send_pkt();

    add({$urandom, $urandom}, 8'hFF, 1'b0);
    add({$urandom, $urandom}, 8'hFF, 1'b0);
    add({$urandom, $urandom}, 8'h01, 1'b1);
    send_pkt();

    add({$urandom, $urandom}, 8'hF0, 1'b0);
    add({$urandom, $urandom}, 8'hFF, 1'b0);
    add({$urandom, $urandom}, 8'hFF, 1'b1);
    send_pkt();
    @(negedge clk);
    chk("flush_stall", s_ready, 0);
    @(negedge clk);
    chk("flush_resume", s_ready, 1);
    @(posedge clk);
    #1;
    drain();

    gaps = 1'b1;
    rnd_ready = 1'b1;
    for (int p = 0; p < 40; p++) begin
      int nb;
      nb = (p % 4 == 0) ? $urandom_range(1, 255) : $urandom_range(1, 5);
      for (int b = 0; b < nb; b++) begin
        int n;
        logic [KW-1:0] k;
        n = $urandom_range(1, KW);
        if (b == nb - 1) k = KW'((1 << n) - 1);
        else if (b == 0) k = KW'(8'hFF << (KW - n));
        else k = '1;
        add({$urandom, $urandom}, k, b == nb - 1);
      end
      send_pkt();
    end
    gaps = 1'b0;
    rnd_ready = 1'b0;
    @(posedge clk);
    #2;
    m_ready = 1'b1;
    drain();

    m_ready = 1'b0;
    send_beat({$urandom, $urandom}, 8'hF0, 1'b0);
    send_beat({$urandom, $urandom}, 8'hFF, 1'b0);
    chk("stalled_valid", m_valid, 1);
    #1;
    rst = 1'b0;
    #1;
    chk("async_reset_outputs", {m_valid, m_last, m_keep, m_data}, 0);
    chk("async_reset_tready", s_ready, 0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b1;
    m_ready = 1'b1;
    add({16'hD1D0, 48'h0}, 8'hC0, 1'b0);
    add({16'h0, 48'hC5C4C3C2C1C0}, 8'h3F, 1'b1);
    send_pkt();
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
